// File: rtl/sc_regbank_fixed_pkg.sv
// Shared definitions for the sc_regbank_fixed register bank.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
`ifndef SC_REGBANK_FIXED_PKG_SV
`define SC_REGBANK_FIXED_PKG_SV

// Part-select of entry idx inside a flat bus made of w-bit entries.
`define SC_REGBANK_SLICE(idx, w) ((idx) * (w)) +: (w)

package sc_regbank_fixed_pkg;

  localparam int MIN_REGS = 2;
  localparam int MAX_REGS = 16;

  // Number of address bits needed to reach every one of 'value' entries.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/sc_regbank_cell.sv
// One register-bank entry: working value, frozen init shadow and dirty bit.
// Latency: load or restore becomes visible on entry_o one cycle after the edge.
// Backpressure: none; restore beats load, and load is ignored unless writable_i.
// Ports: clk/rst, init_i (reset value), load_en_i/load_data_i (write),
//        restore_i (reload from shadow), writable_i, entry_o, dirty_o.
module sc_regbank_cell
  import sc_regbank_fixed_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] init_i,
  input  logic         load_en_i,
  input  logic [W-1:0] load_data_i,
  input  logic         restore_i,
  input  logic         writable_i,
  output logic [W-1:0] entry_o,
  output logic         dirty_o
);

  logic [W-1:0] entry_q, entry_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         dirty_q, dirty_d;

  always_comb begin
    entry_d  = entry_q;
    dirty_d  = dirty_q;
    // The shadow only ever changes under reset.
    shadow_d = shadow_q;
    if (restore_i) begin
      entry_d = shadow_q;
      dirty_d = 1'b0;
    end else if (load_en_i && writable_i) begin
      // Dirty marks "was written", not "differs from init".
      entry_d = load_data_i;
      dirty_d = 1'b1;
    end
  end

  // While reset is held, both copies track the init value on every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q  <= init_i;
      shadow_q <= init_i;
      dirty_q  <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

  assign entry_o = entry_q;
  assign dirty_o = dirty_q;

endmodule

// File: rtl/sc_regbank_fixed.sv
// Register bank with init capture, guarded writes, sticky lock and restore.
// Latency: writes visible on data_OutBUS next cycle; rd_data is 1-cycle registered.
// Backpressure: none; rejected writes are dropped and flagged by a 1-cycle wr_err pulse.
// Ports: clock/reset, init bus, write port (en/addr/data), lock, restore,
//        read port (addr -> registered data), flat data bus, dirty, locked, wr_err.
module sc_regbank_fixed
  import sc_regbank_fixed_pkg::*;
#(
  parameter int                  DATAWIDTH_BUS = 8,
  parameter int                  NUM_REGS      = 4,
  parameter int                  ADDR_WIDTH    = 2,
  parameter logic [NUM_REGS-1:0] WRITABLE_MASK = {NUM_REGS{1'b1}}
) (
  input  logic                              SC_RegBANK_CLOCK_50,
  input  logic                              SC_RegBANK_RESET_InHigh,
  input  logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_RegBANK_init_InBUS,
  input  logic                              SC_RegBANK_wr_en_In,
  input  logic [ADDR_WIDTH-1:0]             SC_RegBANK_wr_addr_InBUS,
  input  logic [DATAWIDTH_BUS-1:0]          SC_RegBANK_wr_data_InBUS,
  input  logic                              SC_RegBANK_lock_In,
  input  logic                              SC_RegBANK_restore_In,
  input  logic [ADDR_WIDTH-1:0]             SC_RegBANK_rd_addr_InBUS,
  output logic [DATAWIDTH_BUS-1:0]          SC_RegBANK_rd_data_OutBUS,
  output logic [NUM_REGS*DATAWIDTH_BUS-1:0] SC_RegBANK_data_OutBUS,
  output logic [NUM_REGS-1:0]               SC_RegBANK_dirty_OutBUS,
  output logic                              SC_RegBANK_locked_Out,
  output logic                              SC_RegBANK_wr_err_Out
);

  localparam int W = DATAWIDTH_BUS;

  generate
    if (NUM_REGS < MIN_REGS || NUM_REGS > MAX_REGS) begin : g_bad_num_regs
      $error("sc_regbank_fixed: NUM_REGS out of range");
    end
    if (clog2(NUM_REGS) > ADDR_WIDTH) begin : g_bad_addr_width
      $error("sc_regbank_fixed: ADDR_WIDTH too small for NUM_REGS");
    end
  endgenerate

  wire clk = SC_RegBANK_CLOCK_50;
  wire rst = SC_RegBANK_RESET_InHigh;

  logic [W-1:0]        entry [NUM_REGS];
  logic [NUM_REGS-1:0] load_en;
  logic                wr_accept;
  logic                locked_q, locked_d;
  logic                wr_err_q, wr_err_d;
  logic [W-1:0]        rd_data_q, rd_data_d;

  always_comb begin
    // Out-of-range addresses simply match no entry, so they never accept.
    wr_accept = 1'b0;
    load_en   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(SC_RegBANK_wr_addr_InBUS) == i && WRITABLE_MASK[i] &&
          SC_RegBANK_wr_en_In && !locked_q) begin
        wr_accept  = 1'b1;
        load_en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    // Lock is judged on its pre-edge value, so a write alongside lock_In lands.
    locked_d = locked_q | SC_RegBANK_lock_In;
    // A restore drops any write in the same cycle, which counts as a rejection.
    if (SC_RegBANK_restore_In) begin
      wr_err_d = SC_RegBANK_wr_en_In;
    end else begin
      wr_err_d = SC_RegBANK_wr_en_In && !wr_accept;
    end
    // Reads sample pre-edge entry state, so they see pre-write/pre-restore data.
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(SC_RegBANK_rd_addr_InBUS) == i) begin
        rd_data_d = entry[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      locked_q  <= locked_d;
      wr_err_q  <= wr_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    sc_regbank_cell #(.W(W)) u_cell (
      .clk         (clk),
      .rst         (rst),
      .init_i      (SC_RegBANK_init_InBUS[`SC_REGBANK_SLICE(g, W)]),
      .load_en_i   (load_en[g]),
      .load_data_i (SC_RegBANK_wr_data_InBUS),
      .restore_i   (SC_RegBANK_restore_In),
      .writable_i  (WRITABLE_MASK[g]),
      .entry_o     (entry[g]),
      .dirty_o     (SC_RegBANK_dirty_OutBUS[g])
    );
    assign SC_RegBANK_data_OutBUS[`SC_REGBANK_SLICE(g, W)] = entry[g];
  end

  assign SC_RegBANK_rd_data_OutBUS = rd_data_q;
  assign SC_RegBANK_locked_Out     = locked_q;
  assign SC_RegBANK_wr_err_Out     = wr_err_q;

endmodule

// File: tb/tb_sc_regbank_fixed.sv
module tb_sc_regbank_fixed;

  localparam int            N    = 4;
  localparam int            W    = 8;
  localparam logic [N-1:0]  MASK = 4'b1110;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] init;
  logic           wr_en;
  logic [1:0]     wr_addr;
  logic [W-1:0]   wr_data;
  logic           lock;
  logic           restore;
  logic [1:0]     rd_addr;
  logic [W-1:0]   rd_data;
  logic [N*W-1:0] data;
  logic [N-1:0]   dirty;
  logic           locked;
  logic           wr_err;

  int compared   = 0;
  int mismatched = 0;

  // Reference state, kept as plain per-entry arrays.
  logic [W-1:0] m_entry  [N];
  logic [W-1:0] m_shadow [N];
  logic [N-1:0] m_dirty;
  logic         m_locked;
  logic         m_err;
  logic [W-1:0] m_rd;

  always #5 clk = ~clk;

  sc_regbank_fixed #(
    .DATAWIDTH_BUS (W),
    .NUM_REGS      (N),
    .ADDR_WIDTH    (2),
    .WRITABLE_MASK (MASK)
  ) dut (
    .SC_RegBANK_CLOCK_50       (clk),
    .SC_RegBANK_RESET_InHigh   (rst),
    .SC_RegBANK_init_InBUS     (init),
    .SC_RegBANK_wr_en_In       (wr_en),
    .SC_RegBANK_wr_addr_InBUS  (wr_addr),
    .SC_RegBANK_wr_data_InBUS  (wr_data),
    .SC_RegBANK_lock_In        (lock),
    .SC_RegBANK_restore_In     (restore),
    .SC_RegBANK_rd_addr_InBUS  (rd_addr),
    .SC_RegBANK_rd_data_OutBUS (rd_data),
    .SC_RegBANK_data_OutBUS    (data),
    .SC_RegBANK_dirty_OutBUS   (dirty),
    .SC_RegBANK_locked_Out     (locked),
    .SC_RegBANK_wr_err_Out     (wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_entry[i]  = init[i*W +: W];
      m_shadow[i] = init[i*W +: W];
    end
    m_dirty  = '0;
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_rd     = '0;
  endtask

  // One clock edge of the bank, straight from its rules.
  task automatic model_edge();
    int a;
    a = int'(wr_addr);
    m_rd = (int'(rd_addr) < N) ? m_entry[int'(rd_addr)] : '0;
    if (restore) begin
      for (int i = 0; i < N; i++) m_entry[i] = m_shadow[i];
      m_dirty = '0;
      m_err   = wr_en;
    end else if (wr_en) begin
      if (a < N && MASK[a] && !m_locked) begin
        m_entry[a] = wr_data;
        m_dirty[a] = 1'b1;
        m_err      = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_err = 1'b0;
    end
    if (lock) m_locked = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [N*W-1:0] packed_m;
    for (int i = 0; i < N; i++) packed_m[i*W +: W] = m_entry[i];
    chk({tag, ".data"},   32'(data),    32'(packed_m));
    chk({tag, ".dirty"},  32'(dirty),   32'(m_dirty));
    chk({tag, ".locked"}, 32'(locked),  32'(m_locked));
    chk({tag, ".wr_err"}, 32'(wr_err),  32'(m_err));
    chk({tag, ".rd"},     32'(rd_data), 32'(m_rd));
  endtask

  // Inputs are changed only after a falling edge; outputs checked at the next one.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle();
    wr_en = 0; lock = 0; restore = 0;
  endtask

  initial begin
    rst = 1; init = 32'h04030201; idle();
    wr_addr = 0; wr_data = 0; rd_addr = 0;
    model_reset();

    // Reset capture
    step("rst0");
    step("rst1");
    rst = 0;
    #1 check_all("rst_rel");
    chk("rst_data_lit", data, 32'h04030201);
    chk("rst_rd_lit", 32'(rd_data), 32'h0);

    // Write then read; same-cycle read returns the pre-write value
    wr_en = 1; wr_addr = 2; wr_data = 8'hAA; rd_addr = 2;
    step("wr2");
    chk("wr2_rd_old", 32'(rd_data), 32'h03);
    idle();
    step("rd2");
    chk("rd2_lit", 32'(rd_data), 32'hAA);
    chk("wr2_dirty_lit", 32'(dirty), 32'b0100);

    // Fixed entry 0 rejects the write for exactly one cycle
    wr_en = 1; wr_addr = 0; wr_data = 8'h55;
    step("fixed");
    chk("fixed_err_lit", 32'(wr_err), 32'h1);
    chk("fixed_e0_lit", 32'(data[7:0]), 32'h01);
    idle();
    step("fixed_clr");

    // Restore colliding with a write; read shows the pre-restore value
    wr_en = 1; wr_addr = 1; wr_data = 8'h5A; step("w1");
    wr_addr = 3; wr_data = 8'hC3; step("w3");
    wr_addr = 2; wr_data = 8'h99; restore = 1; rd_addr = 3;
    step("restore");
    chk("restore_data_lit", data, 32'h04030201);
    chk("restore_rd_lit", 32'(rd_data), 32'hC3);
    chk("restore_err_lit", 32'(wr_err), 32'h1);
    idle();
    step("restore_clr");

    // Lock: write alongside lock lands, later write is rejected
    lock = 1; wr_en = 1; wr_addr = 1; wr_data = 8'h11; rd_addr = 1;
    step("lock_wr");
    chk("lock_wr_lit", 32'(data[15:8]), 32'h11);
    lock = 0; wr_data = 8'h22;
    step("locked_wr");
    chk("locked_err_lit", 32'(wr_err), 32'h1);
    idle();
    repeat (3) step("locked_hold");
    chk("locked_lit", 32'(locked), 32'h1);
    restore = 1;
    step("restore_locked");
    idle();
    step("restore_locked_clr");

    // Asynchronous reset mid-write, with a new init value to capture
    wr_en = 1; wr_addr = 3; wr_data = 8'h77;
    #2 rst = 1;
    model_reset();
    #1 check_all("async_rst");
    chk("async_locked_lit", 32'(locked), 32'h0);
    step("async_hold");
    rst = 0; idle();
    step("async_rel");

    // Randomised traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        init = $urandom;
        rst = 1;
        step("rnd_rst");
        rst = 0;
      end
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 8'($urandom);
      rd_addr = 2'($urandom_range(0, 3));
      lock    = ($urandom_range(0, 63) == 0);
      restore = ($urandom_range(0, 11) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sc_regbank_fixed.md
Name: sc_regbank_fixed

Overview:
- NUM_REGS-entry register bank with one write port and one registered read port.
- Each entry captures its own initial value from a parallel init bus while reset is high, and keeps that value in a shadow copy.
- After reset, the bank supports guarded writes, a sticky write lock, a one-cycle restore-to-init and per-entry dirty tracking.
- It holds the datapath's configurable constants and operands, e.g. the Collatz seed and limits.

Parameters:
- DATAWIDTH_BUS, 8, width of each entry.
- NUM_REGS, 4, number of entries (2..16).
- ADDR_WIDTH, 2, address width; must satisfy 2**ADDR_WIDTH >= NUM_REGS.
- WRITABLE_MASK, {NUM_REGS{1'b1}}, bit i=1 makes entry i writable after reset; bit i=0 makes it fixed (init-only).

Ports:
- SC_RegBANK_CLOCK_50  in  1  system clock; all state changes on its rising edge.
- SC_RegBANK_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_RegBANK_init_InBUS  in  NUM_REGS*DATAWIDTH_BUS  init values; entry i is slice [i*W +: W].
- SC_RegBANK_wr_en_In  in  1  write request.
- SC_RegBANK_wr_addr_InBUS  in  ADDR_WIDTH  write address.
- SC_RegBANK_wr_data_InBUS  in  DATAWIDTH_BUS  write data.
- SC_RegBANK_lock_In  in  1  sets the sticky lock.
- SC_RegBANK_restore_In  in  1  reload all entries from shadow.
- SC_RegBANK_rd_addr_InBUS  in  ADDR_WIDTH  read address.
- SC_RegBANK_rd_data_OutBUS  out  DATAWIDTH_BUS  registered read data.
- SC_RegBANK_data_OutBUS  out  NUM_REGS*DATAWIDTH_BUS  all entries, combinational from state.
- SC_RegBANK_dirty_OutBUS  out  NUM_REGS  entry i written since reset or last restore.
- SC_RegBANK_locked_Out  out  1  lock state.
- SC_RegBANK_wr_err_Out  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- While reset is high (asynchronous, level):
  - entry[i] and shadow[i] continuously follow init slice i.
  - dirty=0, locked=0, wr_err=0, rd_data=0.
- After reset deasserts, shadow is frozen until the next reset.
- Per-edge priority, evaluated each rising edge:
  1. restore=1: all entries load shadow; dirty=0. Any simultaneous write is dropped and wr_err=1.
  2. Else wr_en=1 is accepted iff wr_addr<NUM_REGS, WRITABLE_MASK[wr_addr]=1 and locked=0 (the pre-edge value).
     - Accepted: entry[wr_addr]<=wr_data and dirty[wr_addr]<=1, even if the data equals the shadow value.
     - Rejected: no state change; wr_err=1 for exactly the next cycle.
  3. wr_err=0 on every edge without a rejected write.
- Lock:
  - lock_In=1 at an edge sets locked from the next cycle; only reset clears it.
  - A write in the same cycle as lock_In is judged on the old lock value, so it is accepted.
  - Restore is permitted while locked.
- Read port:
  - rd_data <= entry[rd_addr] at each edge, giving a 1-cycle latency.
  - rd_addr>=NUM_REGS returns 0.
  - Read and write to the same address in the same cycle returns the pre-write value.
  - Read and restore in the same cycle returns the pre-restore value.
- Combinational output: data_OutBUS reflects entry state only; there is no combinational path from any input.
- Arithmetic: none; no wrap-around. Out-of-range addresses are handled as above.
- Reset mid-operation: a write or restore in flight is abandoned and every output takes its reset value immediately.

Decomposition:
- Shared package/include:
  - clog2 helper for ADDR_WIDTH checking;
  - slice-index macro for flat buses;
  - elaboration-time assertion that NUM_REGS <= 2**ADDR_WIDTH.
- Sub-module sc_regbank_cell, one instance per entry. Contents:
  - entry and shadow registers;
  - dirty bit;
  - inputs init, load_en, load_data, restore, writable.
- Top level holds address decode, lock, wr_err and the read mux/register.

Test Plan:
- Reset: reset high with init={8'h04,8'h03,8'h02,8'h01}, then low -> data_OutBUS=32'h04030201, dirty=0, rd_data=0, locked=0.
- Write and read: write 8'hAA to addr 2; next cycle rd_addr=2 -> data slice 2=8'hAA and dirty=4'b0100; rd_data=8'hAA one cycle after rd_addr is applied.
- Fixed entry: WRITABLE_MASK=4'b1110, write 8'h55 to addr 0 -> entry 0 stays 8'h01, wr_err high exactly one cycle, dirty unchanged.
- Lock: lock_In pulsed together with a write of 8'h11 to addr 1 -> accepted; a following write of 8'h22 to addr 1 -> rejected with wr_err; locked=1 until reset.
- Restore with collision: after writes to addrs 1 and 3, assert restore together with a write to addr 2 -> entries return to 32'h04030201, dirty=0, wr_err pulses; rd_data on that edge shows the old value.
- Async reset mid-write: assert reset between clock edges while wr_en=1 -> outputs go to init values and reset values before the next edge, and the write has no effect.
